// File: rtl/mult_pkg.sv
// ----------------------------------------------------------------------------
// mult_pkg
//   Shared definitions for the sequential radix-4 Booth multiplier.
//   - state_t     : controller states IDLE / RUN / DONE
//   - BSEL_*      : Booth digit select codes, {negate, magnitude[1:0]}
//                   where magnitude 2'b00 = 0, 2'b01 = 1x, 2'b10 = 2x
//   - niter()     : number of Booth digits processed for a given operand width
// ----------------------------------------------------------------------------
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] BSEL_ZERO = 3'b000;
    localparam logic [2:0] BSEL_POS1 = 3'b001;
    localparam logic [2:0] BSEL_POS2 = 3'b010;
    localparam logic [2:0] BSEL_NEG1 = 3'b101;
    localparam logic [2:0] BSEL_NEG2 = 3'b110;

    // Operands are extended by two bits, so (width+2)/2 radix-4 digits
    // cover the whole extended multiplier.
    function automatic int niter(input int width);
        return (width + 2) / 2;
    endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// ----------------------------------------------------------------------------
// booth_r4_enc
//   Radix-4 Booth recoder for one overlapping multiplier triplet
//   {y[2i+1], y[2i], y[2i-1]}.
//   Ports:
//     digit  in   3  multiplier triplet
//     mag    out  2  magnitude select: 2'b00 = 0, 2'b01 = 1x, 2'b10 = 2x
//     neg    out  1  negate the selected multiple
// ----------------------------------------------------------------------------
module booth_r4_enc
    import mult_pkg::*;
(
    input  logic [2:0] digit,
    output logic [1:0] mag,
    output logic       neg
);

    logic [2:0] bsel;

    always_comb begin
        case (digit)
            3'b000, 3'b111: bsel = BSEL_ZERO;
            3'b001, 3'b010: bsel = BSEL_POS1;
            3'b011:         bsel = BSEL_POS2;
            3'b100:         bsel = BSEL_NEG2;
            3'b101, 3'b110: bsel = BSEL_NEG1;
            default:        bsel = BSEL_ZERO;
        endcase
    end

    assign mag = bsel[1:0];
    assign neg = bsel[2];

endmodule

// File: rtl/seq_booth_mult.sv
// ----------------------------------------------------------------------------
// seq_booth_mult
//   Sequential two's-complement multiplier, radix-4 Booth, one digit per clock.
//   Latency from the accept edge to out_valid is niter(WIDTH) cycles.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready
//   are both high. in_ready is high only in IDLE; out_valid is high only in
//   DONE and, once high, it and p stay stable until out_ready is seen.
//
//   Optional build macro MULT_SIGN_SEL_EN adds the in_signed port; without it
//   operands are always treated as signed.
//
//   Ports:
//     clk        in   1         rising-edge clock
//     rst        in   1         asynchronous, active-high reset
//     in_valid   in   1         x/y valid
//     in_ready   out  1         ready to accept operands (IDLE)
//     x, y       in   WIDTH     multiplicand, multiplier
//     in_signed  in   1         (MULT_SIGN_SEL_EN only) 1 = signed, 0 = unsigned
//     out_valid  out  1         p holds a finished product
//     out_ready  in   1         consumer takes p
//     p          out  2*WIDTH   exact product
//     busy       out  1         RUN or DONE
// ----------------------------------------------------------------------------
module seq_booth_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
`ifdef MULT_SIGN_SEL_EN
    input  logic                 in_signed,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int EW    = WIDTH + 2;
    localparam int PW    = 2 * WIDTH;
    localparam int NITER = niter(WIDTH);
    localparam int CW    = $clog2(NITER + 1);

    // The product is exact in PW bits, so the accumulator and the multiplicand
    // only need to be kept modulo 2^PW; bits above PW never reach p.
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    xm_q, xm_d;
    logic [EW:0]      yb_q, yb_d;     // {y_ext, implicit y[-1]=0}, shifted 2 per digit
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    p_q, p_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    // Operand extension
    logic             ext_signed;
    logic [PW-1:0]    xm_in;
    logic [EW:0]      yb_in;

`ifdef MULT_SIGN_SEL_EN
    assign ext_signed = in_signed;
`else
    assign ext_signed = 1'b1;
`endif

    assign xm_in = {{WIDTH{ext_signed & x[WIDTH-1]}}, x};
    assign yb_in = {{2{ext_signed & y[WIDTH-1]}}, y, 1'b0};

    // Booth digit for the current iteration is always the low triplet.
    logic [1:0]       mag;
    logic             neg;

    booth_r4_enc u_enc (
        .digit (yb_q[2:0]),
        .mag   (mag),
        .neg   (neg)
    );

    logic [PW-1:0]    pp_mag;
    logic [PW-1:0]    pp;
    logic [PW-1:0]    acc_sum;

    always_comb begin
        case (mag)
            2'b01:   pp_mag = xm_q;
            2'b10:   pp_mag = xm_q << 1;
            default: pp_mag = '0;
        endcase
    end

    assign pp      = neg ? (~pp_mag + 1'b1) : pp_mag;
    // Digit i carries weight 4^i.
    assign acc_sum = acc_q + (pp << {cnt_q, 1'b0});

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        xm_d        = xm_q;
        yb_d        = yb_q;
        acc_d       = acc_q;
        p_d         = p_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d    = RUN;
                    cnt_d      = '0;
                    xm_d       = xm_in;
                    yb_d       = yb_in;
                    acc_d      = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            RUN: begin
                acc_d = acc_sum;
                yb_d  = yb_q >> 2;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NITER - 1)) begin
                    state_d     = DONE;
                    p_d         = acc_sum;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            xm_q        <= '0;
            yb_q        <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            xm_q        <= xm_d;
            yb_q        <= yb_d;
            acc_q       <= acc_d;
            p_q         <= p_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign p         = p_q;
    assign busy      = busy_q;

endmodule
